// File: rtl/dircc_status_client_if.sv
// Bundled command, response and status-memory signals of the status client.
// The client itself connects through the slave modport; whatever issues
// commands and models the status register uses the master modport.
interface dircc_status_client_if #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int MEM_WIDTH     = 16
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [15:0]              cmd_state;
  logic [15:0]              cmd_extra;
  logic                     rsp_valid;
  logic [15:0]              rsp_state;
  logic [15:0]              rsp_extra;
  logic [63:0]              rsp_user;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_write;
  logic [MEM_WIDTH-1:0]     mem_writedata;
  logic [MEM_WIDTH-1:0]     mem_readdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_state, cmd_extra, mem_readdata,
    output cmd_ready, rsp_valid, rsp_state, rsp_extra, rsp_user,
           mem_address, mem_write, mem_writedata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_state, cmd_extra, mem_readdata,
    input  cmd_ready, rsp_valid, rsp_state, rsp_extra, rsp_user,
           mem_address, mem_write, mem_writedata
  );
endinterface

// File: rtl/dircc_status_client.sv
// Status-register client: runs read / read-modify-write / write sequences
// against a zero-wait-state halfword memory holding a state halfword, an
// extra-state halfword and four user halfwords. Every output is registered.
// The halfword datapath is 16 bits wide; MEM_WIDTH is expected to be 16.
module dircc_status_client #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int MEM_WIDTH     = 16,
  parameter int BASE_ADDRESS  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  dircc_status_client_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_READ_STATE = 2'd0;
  localparam logic [1:0] OP_SET_OR     = 2'd1;
  localparam logic [1:0] OP_SET_EXCL   = 2'd2;
  localparam logic [1:0] OP_READ_USER  = 2'd3;

  localparam logic [3:0] OFF_STATE = 4'd0;
  localparam logic [3:0] OFF_EXTRA = 4'd2;
  localparam logic [3:0] OFF_USER  = 4'd4;

  localparam logic [ADDRESS_WIDTH-1:0] BASE_ADDR = ADDRESS_WIDTH'(BASE_ADDRESS);

  // Byte address of a halfword; the sum is truncated so it wraps at the top.
  function automatic logic [ADDRESS_WIDTH-1:0] f_addr(input logic [3:0] i_off);
    f_addr = BASE_ADDR + ADDRESS_WIDTH'(i_off);
  endfunction

  state_t                   r_state;
  logic [1:0]               r_op;
  logic [15:0]              r_cmd_state;
  logic [15:0]              r_cmd_extra;
  logic                     r_half;       // 0: state halfword, 1: extra halfword
  logic [1:0]               r_word_cnt;   // user halfword index for READ_USER
  logic [15:0]              r_cap_state;  // state value reported at DONE
  logic [47:0]              r_user_buf;   // first three user halfwords
  logic                     r_cmd_ready;
  logic                     r_rsp_valid;
  logic [15:0]              r_rsp_state;
  logic [15:0]              r_rsp_extra;
  logic [63:0]              r_rsp_user;
  logic [ADDRESS_WIDTH-1:0] r_mem_address;
  logic                     r_mem_write;
  logic [MEM_WIDTH-1:0]     r_mem_writedata;

  logic                     w_accept;
  logic [15:0]              w_rd;
  logic [15:0]              w_or;
  logic [1:0]               w_cnt_next;
  logic [3:0]               w_user_off;

  assign w_accept   = bus.cmd_valid && r_cmd_ready;
  assign w_rd       = 16'(bus.mem_readdata);
  assign w_or       = w_rd | r_cmd_state;
  assign w_cnt_next = r_word_cnt + 2'd1;
  assign w_user_off = OFF_USER + {1'b0, w_cnt_next, 1'b0};

  // Command FSM: sequences the halfword accesses and drives all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_op            <= OP_READ_STATE;
      r_cmd_state     <= 16'h0000;
      r_cmd_extra     <= 16'h0000;
      r_half          <= 1'b0;
      r_word_cnt      <= 2'd0;
      r_cap_state     <= 16'h0000;
      r_user_buf      <= 48'h0;
      r_cmd_ready     <= 1'b1;
      r_rsp_valid     <= 1'b0;
      r_rsp_state     <= 16'h0000;
      r_rsp_extra     <= 16'h0000;
      r_rsp_user      <= 64'h0;
      r_mem_address   <= BASE_ADDR;
      r_mem_write     <= 1'b0;
      r_mem_writedata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready   <= 1'b1;
          r_mem_write   <= 1'b0;
          r_mem_address <= BASE_ADDR;
          if (w_accept) begin
            // Operands are captured here; later input changes are ignored.
            r_op        <= bus.cmd_op;
            r_cmd_state <= bus.cmd_state;
            r_cmd_extra <= bus.cmd_extra;
            r_word_cnt  <= 2'd0;
            r_half      <= 1'b0;
            r_cmd_ready <= 1'b0;
            case (bus.cmd_op)
              OP_SET_EXCL: begin
                r_state         <= S_WR;
                r_mem_address   <= f_addr(OFF_STATE);
                r_mem_write     <= 1'b1;
                r_mem_writedata <= MEM_WIDTH'(bus.cmd_state);
                r_cap_state     <= bus.cmd_state;
              end
              OP_READ_USER: begin
                r_state       <= S_RD;
                r_mem_address <= f_addr(OFF_USER);
              end
              OP_READ_STATE, OP_SET_OR: begin
                r_state       <= S_RD;
                r_mem_address <= f_addr(OFF_STATE);
              end
              default: begin
                r_state       <= S_RD;
                r_mem_address <= f_addr(OFF_STATE);
              end
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_RD: begin
          // Address stays put; read data arrives during the next cycle.
          r_state <= S_CAP;
        end

        S_CAP: begin
          case (r_op)
            OP_SET_OR: begin
              // Read-modify-write of the state halfword, same address.
              r_cap_state     <= w_or;
              r_state         <= S_WR;
              r_mem_write     <= 1'b1;
              r_mem_writedata <= MEM_WIDTH'(w_or);
            end
            OP_READ_USER: begin
              if (r_word_cnt == 2'd3) begin
                r_rsp_user    <= {w_rd, r_user_buf};
                r_rsp_valid   <= 1'b1;
                r_mem_address <= BASE_ADDR;
                r_state       <= S_DONE;
              end else begin
                r_user_buf    <= {w_rd, r_user_buf[47:16]};
                r_word_cnt    <= w_cnt_next;
                r_mem_address <= f_addr(w_user_off);
                r_state       <= S_RD;
              end
            end
            default: begin
              // READ_STATE: state halfword first, then extra halfword.
              if (!r_half) begin
                r_cap_state   <= w_rd;
                r_half        <= 1'b1;
                r_mem_address <= f_addr(OFF_EXTRA);
                r_state       <= S_RD;
              end else begin
                r_rsp_state   <= r_cap_state;
                r_rsp_extra   <= w_rd;
                r_rsp_valid   <= 1'b1;
                r_mem_address <= BASE_ADDR;
                r_state       <= S_DONE;
              end
            end
          endcase
        end

        S_WR: begin
          if (!r_half) begin
            r_half          <= 1'b1;
            r_mem_address   <= f_addr(OFF_EXTRA);
            r_mem_write     <= 1'b1;
            r_mem_writedata <= MEM_WIDTH'(r_cmd_extra);
            r_state         <= S_WR;
          end else begin
            r_mem_write   <= 1'b0;
            r_mem_address <= BASE_ADDR;
            r_rsp_state   <= r_cap_state;
            r_rsp_extra   <= r_cmd_extra;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_DONE;
          end
        end

        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end

        default: begin
          r_state       <= S_IDLE;
          r_cmd_ready   <= 1'b1;
          r_mem_write   <= 1'b0;
          r_mem_address <= BASE_ADDR;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = r_cmd_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_state     = r_rsp_state;
  assign bus.rsp_extra     = r_rsp_extra;
  assign bus.rsp_user      = r_rsp_user;
  assign bus.mem_address   = r_mem_address;
  assign bus.mem_write     = r_mem_write;
  assign bus.mem_writedata = r_mem_writedata;

endmodule

// File: tb/tb_dircc_status_client.sv
// Scoreboard bench for dircc_status_client: three instances (base 0, 0x7FFC,
// 0x7FFE). Issued commands push a per-cycle bus trace plus expected response;
// a negedge monitor pops and compares independently of the stimulus.
module tb_dircc_status_client;
  localparam int AW = 15;
  localparam int MW = 16;
  localparam logic [1:0] OP_RS = 2'd0;
  localparam logic [1:0] OP_OR = 2'd1;
  localparam logic [1:0] OP_EX = 2'd2;
  localparam logic [1:0] OP_RU = 2'd3;

  typedef struct packed {
    logic [1:0]        id;
    logic [3:0]        lat;
    logic [8:0][14:0]  addr;
    logic [8:0]        wr;
    logic [8:0][15:0]  wdata;
    logic [15:0]       st;
    logic [15:0]       ex;
    logic [63:0]       usr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dircc_status_client_if #(.ADDRESS_WIDTH(AW), .MEM_WIDTH(MW)) bus0();
  dircc_status_client_if #(.ADDRESS_WIDTH(AW), .MEM_WIDTH(MW)) bus1();
  dircc_status_client_if #(.ADDRESS_WIDTH(AW), .MEM_WIDTH(MW)) bus2();

  dircc_status_client #(.ADDRESS_WIDTH(AW), .MEM_WIDTH(MW), .BASE_ADDRESS(0))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dircc_status_client #(.ADDRESS_WIDTH(AW), .MEM_WIDTH(MW), .BASE_ADDRESS(32'h7FFC))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  dircc_status_client #(.ADDRESS_WIDTH(AW), .MEM_WIDTH(MW), .BASE_ADDRESS(32'h7FFE))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [14:0] bases [3] = '{15'h0000, 15'h7FFC, 15'h7FFE};

  // Status memory for instance 0 (halfword index = address[3:1]) with preload port
  logic [15:0] mem [8];
  logic        pre_we;
  logic [2:0]  pre_idx;
  logic [15:0] pre_data;
  always @(posedge clk) begin
    bus0.mem_readdata <= mem[bus0.mem_address[3:1]];
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (bus0.mem_write) mem[bus0.mem_address[3:1]] <= bus0.mem_writedata;
  end

  // Instances 1/2 read back address ^ 0xA5A5 with one cycle of latency
  always @(posedge clk) begin
    bus1.mem_readdata <= 16'(bus1.mem_address) ^ 16'hA5A5;
    bus2.mem_readdata <= 16'(bus2.mem_address) ^ 16'hA5A5;
  end

  logic [14:0] m_addr [3];
  logic        m_wr   [3];
  logic [15:0] m_wd   [3];
  logic        m_rv   [3];
  logic        m_rdy  [3];
  logic        m_val  [3];
  logic [15:0] m_st   [3];
  logic [15:0] m_ex   [3];
  logic [63:0] m_usr  [3];
  // Per-instance views so the monitor can select the instance under test
  always_comb begin
    m_addr = '{bus0.mem_address, bus1.mem_address, bus2.mem_address};
    m_wr   = '{bus0.mem_write, bus1.mem_write, bus2.mem_write};
    m_wd   = '{bus0.mem_writedata, bus1.mem_writedata, bus2.mem_writedata};
    m_rv   = '{bus0.rsp_valid, bus1.rsp_valid, bus2.rsp_valid};
    m_rdy  = '{bus0.cmd_ready, bus1.cmd_ready, bus2.cmd_ready};
    m_val  = '{bus0.cmd_valid, bus1.cmd_valid, bus2.cmd_valid};
    m_st   = '{bus0.rsp_state, bus1.rsp_state, bus2.rsp_state};
    m_ex   = '{bus0.rsp_extra, bus1.rsp_extra, bus2.rsp_extra};
    m_usr  = '{bus0.rsp_user, bus1.rsp_user, bus2.rsp_user};
  end

  int   checks = 0;
  int   errors = 0;
  int   cur_id = 0;
  bit   active = 1'b0;
  int   cyc    = 0;
  exp_t cur;
  exp_t sb_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Expected per-cycle bus trace and response for one command
  function automatic exp_t build(input logic [1:0] id, input logic [1:0] op,
                                 input logic [14:0] base, input logic [15:0] st,
                                 input logic [15:0] ex, input logic [63:0] usr);
    exp_t e;
    e = '0;
    e.id = id; e.st = st; e.ex = ex; e.usr = usr;
    case (op)
      OP_RS: begin
        e.lat = 4'd5;
        e.addr[0] = base; e.addr[1] = base;
        e.addr[2] = 15'(base + 15'd2); e.addr[3] = 15'(base + 15'd2);
        e.addr[4] = base;
      end
      OP_OR: begin
        e.lat = 4'd5;
        e.addr[0] = base; e.addr[1] = base; e.addr[2] = base;
        e.wr[2] = 1'b1; e.wdata[2] = st;
        e.addr[3] = 15'(base + 15'd2); e.wr[3] = 1'b1; e.wdata[3] = ex;
        e.addr[4] = base;
      end
      OP_EX: begin
        e.lat = 4'd3;
        e.addr[0] = base; e.wr[0] = 1'b1; e.wdata[0] = st;
        e.addr[1] = 15'(base + 15'd2); e.wr[1] = 1'b1; e.wdata[1] = ex;
        e.addr[2] = base;
      end
      default: begin
        e.lat = 4'd9;
        for (int k = 0; k < 4; k++) begin
          e.addr[2*k]   = 15'(base + 15'(4 + 2*k));
          e.addr[2*k+1] = 15'(base + 15'(4 + 2*k));
        end
        e.addr[8] = base;
      end
    endcase
    return e;
  endfunction

  // Monitor: reset checks, busy-cycle trace checks, idle checks, acceptance
  always @(negedge clk) begin
    if (reset) begin
      active = 1'b0;
      sb_q.delete();
      chk("rst_cmd_ready", 64'(m_rdy[cur_id]), 64'd1);
      chk("rst_rsp_valid", 64'(m_rv[cur_id]), 64'd0);
      chk("rst_mem_write", 64'(m_wr[cur_id]), 64'd0);
      chk("rst_mem_address", 64'(m_addr[cur_id]), 64'(bases[cur_id]));
    end else if (active) begin
      cyc++;
      chk("busy_cmd_ready", 64'(m_rdy[cur_id]), 64'd0);
      chk("mem_address", 64'(m_addr[cur_id]), 64'(cur.addr[cyc-1]));
      chk("mem_write", 64'(m_wr[cur_id]), 64'(cur.wr[cyc-1]));
      if (cur.wr[cyc-1]) chk("mem_writedata", 64'(m_wd[cur_id]), 64'(cur.wdata[cyc-1]));
      chk("rsp_valid", 64'(m_rv[cur_id]), 64'(cyc == int'(cur.lat)));
      if (cyc == int'(cur.lat)) begin
        chk("rsp_state", 64'(m_st[cur_id]), 64'(cur.st));
        chk("rsp_extra", 64'(m_ex[cur_id]), 64'(cur.ex));
        chk("rsp_user", m_usr[cur_id], cur.usr);
        active = 1'b0;
      end
    end else begin
      chk("idle_rsp_valid", 64'(m_rv[cur_id]), 64'd0);
      chk("idle_mem_write", 64'(m_wr[cur_id]), 64'd0);
      chk("idle_cmd_ready", 64'(m_rdy[cur_id]), 64'd1);
      chk("idle_mem_address", 64'(m_addr[cur_id]), 64'(bases[cur_id]));
      if (m_val[cur_id] && m_rdy[cur_id]) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_accept actual=accept expected=none (t=%0t)", $time);
        end else begin
          cur = sb_q.pop_front();
          chk("sb_id", 64'(cur.id), 64'(cur_id));
          active = 1'b1;
          cyc = 0;
        end
      end
    end
  end

  task automatic drive(input int id, input logic v, input logic [1:0] op,
                       input logic [15:0] st, input logic [15:0] ex);
    if (id == 0) begin
      bus0.cmd_valid = v; bus0.cmd_op = op; bus0.cmd_state = st; bus0.cmd_extra = ex;
    end else if (id == 1) begin
      bus1.cmd_valid = v; bus1.cmd_op = op; bus1.cmd_state = st; bus1.cmd_extra = ex;
    end else begin
      bus2.cmd_valid = v; bus2.cmd_op = op; bus2.cmd_state = st; bus2.cmd_extra = ex;
    end
  endtask

  // Returns at posedge+1 after the accepting edge; n = negedges waited
  task automatic wait_accept(input int id, output int n);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (m_val[id] && m_rdy[id]) break;
    end
    if (!(m_val[id] && m_rdy[id])) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=no_accept expected=accept id=%0d", id);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input int id, input logic [1:0] op, input logic [15:0] st,
                       input logic [15:0] ex, input logic [15:0] e_st,
                       input logic [15:0] e_ex, input logic [63:0] e_usr, input bit hold);
    int n;
    sb_q.push_back(build(2'(id), op, bases[id], e_st, e_ex, e_usr));
    drive(id, 1'b1, op, st, ex);
    wait_accept(id, n);
    if (!hold) drive(id, 1'b0, op, st, ex);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((active || sb_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (active || sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL op_timeout actual=busy expected=done (t=%0t)", $time);
    end
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [2:0] idx, input logic [15:0] d);
    pre_we = 1'b1; pre_idx = idx; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    pre_we = 1'b0; pre_idx = 3'd0; pre_data = 16'h0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, OP_RS, 16'h0, 16'h0);
    #1;
    for (int i = 0; i < 8; i++) preload(3'(i), 16'h0000);
    chk("rst_rsp_state", 64'(bus0.rsp_state), 64'h0);
    chk("rst_rsp_extra", 64'(bus0.rsp_extra), 64'h0);
    chk("rst_rsp_user", bus0.rsp_user, 64'h0);
    chk("rst_mem_writedata", 64'(bus0.mem_writedata), 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Exclusive set: two writes, response after 3 cycles
    issue(0, OP_EX, 16'h0005, 16'h1234, 16'h0005, 16'h1234, 64'h0, 1'b0);
    wait_done();
    // OR set on hw@0=0x0005: writes 0x0035 then 0xBEEF
    issue(0, OP_OR, 16'h0030, 16'hBEEF, 16'h0035, 16'hBEEF, 64'h0, 1'b0);
    wait_done();
    // Read back state and extra
    issue(0, OP_RS, 16'hFFFF, 16'hFFFF, 16'h0035, 16'hBEEF, 64'h0, 1'b0);
    wait_done();
    // Bytes 4..11 = 0x01..0x08, then read user state
    preload(3'd2, 16'h0201); preload(3'd3, 16'h0403);
    preload(3'd4, 16'h0605); preload(3'd5, 16'h0807);
    issue(0, OP_RU, 16'h0, 16'h0, 16'h0035, 16'hBEEF, 64'h0807060504030201, 1'b0);
    wait_done();

    // Valid held through a READ_USER; operands change right after acceptance
    issue(0, OP_RU, 16'h0, 16'h0, 16'h0035, 16'hBEEF, 64'h0807060504030201, 1'b1);
    sb_q.push_back(build(2'd0, OP_EX, bases[0], 16'hA000, 16'h00C3, 64'h0807060504030201));
    drive(0, 1'b1, OP_EX, 16'hA000, 16'h00C3);
    wait_accept(0, n);
    drive(0, 1'b0, OP_EX, 16'h0, 16'h0);
    chk("held_cmd_wait", 64'(n), 64'd10);
    wait_done();

    // OR onto 0xA000
    issue(0, OP_OR, 16'h0F0F, 16'h5555, 16'hAF0F, 16'h5555, 64'h0807060504030201, 1'b0);
    wait_done();

    // Reset asserted in the WR@0 cycle of a SET_OR
    issue(0, OP_OR, 16'h0001, 16'h7777, 16'hAF0F, 16'h7777, 64'h0807060504030201, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wr0_write", 64'(bus0.mem_write), 64'd1);
    chk("wr0_address", 64'(bus0.mem_address), 64'h0);
    reset = 1'b1;
    #1;
    chk("async_write_drop", 64'(bus0.mem_write), 64'd0);
    chk("async_cmd_ready", 64'(bus0.cmd_ready), 64'd1);
    @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_mem0", 64'(mem[0]), 64'hAF0F);
    chk("abort_mem1", 64'(mem[1]), 64'h5555);
    chk("abort_rsp_state", 64'(bus0.rsp_state), 64'h0);
    chk("abort_rsp_user", bus0.rsp_user, 64'h0);
    issue(0, OP_RS, 16'h0, 16'h0, 16'hAF0F, 16'h5555, 64'h0, 1'b0);
    wait_done();

    // Base 0x7FFC: addresses 0x7FFC, 0x7FFE
    cur_id = 1;
    @(posedge clk); #1;
    issue(1, OP_RS, 16'h0, 16'h0, 16'hDA59, 16'hDA5B, 64'h0, 1'b0);
    wait_done();
    // Base 0x7FFE: second address wraps to 0x0000
    cur_id = 2;
    @(posedge clk); #1;
    issue(2, OP_RS, 16'h0, 16'h0, 16'hDA5B, 16'hA5A5, 64'h0, 1'b0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
